// File: rtl/tagger_run_controller.sv
// tagger_run_controller
//   Run sequencer for the multichannel event tagger. Turns start/stop/clear
//   command pulses into the tagger's reset_counter / counter_operate /
//   capture_operate controls, buffers the tagger record stream in a small
//   first-word-fall-through FIFO for a back-pressured consumer, enforces an
//   optional per-run channel-record limit and accounts for overflow drops.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   cmd_start/stop/clear one-cycle command pulses
//   record_limit        channel records per run (0 = unlimited), latched on start
//   tag_data, tag_ready record stream from the tagger
//   reset_counter, counter_operate, capture_operate  registered tagger controls
//   out_data, out_valid, out_accept                  FWFT record output
//   busy, done          not-idle flag, one-cycle run-complete pulse
//   overflow, lost_count, record_count               per-run statistics
module tagger_run_controller #(
    parameter int N_CHANNELS   = 4,
    parameter int DATA_WIDTH   = 47,
    parameter int FIFO_DEPTH   = 4,
    parameter int LIMIT_WIDTH  = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_start,
    input  logic                   cmd_stop,
    input  logic                   cmd_clear,
    input  logic [LIMIT_WIDTH-1:0] record_limit,
    input  logic [DATA_WIDTH-1:0]  tag_data,
    input  logic                   tag_ready,
    output logic                   reset_counter,
    output logic                   counter_operate,
    output logic                   capture_operate,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_accept,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [15:0]            lost_count,
    output logic [LIMIT_WIDTH-1:0] record_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DCW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   clr_run_q, clr_run_d;   // CLEAR belongs to a run start
    logic [DCW-1:0]         drain_cnt_q;
    logic [LIMIT_WIDTH-1:0] limit_q;
    logic [LIMIT_WIDTH-1:0] count_q, count_d, count_max;
    logic [15:0]            lost_q;
    logic                   ovf_q;
    logic                   rst_cnt_q, cnt_op_q, cap_op_q, done_q;

    // FIFO storage
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       fcnt_q, fcnt_d;

    logic in_capture, limit_hit, accept, is_chan;
    logic fifo_empty, fifo_full, pop, push, drop, count_inc, drain_done;

    // ------------------------------------------------------------------
    // Record acceptance / FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        in_capture = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        limit_hit  = (limit_q != '0) && (count_q == limit_q);
        // Records past the limit vanish without touching drop statistics.
        accept     = in_capture && tag_ready && !limit_hit;
        is_chan    = |tag_data[36 +: N_CHANNELS];

        fifo_empty = (fcnt_q == '0);
        fifo_full  = (fcnt_q == CNT_W'(FIFO_DEPTH));
        pop        = !fifo_empty && out_accept;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push       = accept && (!fifo_full || pop);
        drop       = accept && fifo_full && !pop;

        fcnt_d = fcnt_q;
        if (push && !pop)      fcnt_d = fcnt_q + CNT_W'(1);
        else if (pop && !push) fcnt_d = fcnt_q - CNT_W'(1);

        count_max = (limit_q == '0) ? '1 : limit_q;
        count_inc = push && is_chan && (count_q != count_max);
        count_d   = count_q + LIMIT_WIDTH'(count_inc);

        drain_done = (drain_cnt_q == DCW'(DRAIN_CYCLES - 1));
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_run_d = clr_run_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d   = ST_CLEAR;
                    clr_run_d = 1'b1;
                end else if (cmd_clear) begin
                    state_d   = ST_CLEAR;
                    clr_run_d = 1'b0;
                end
            end
            ST_CLEAR: state_d = clr_run_q ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                // Limit compares against the count including this cycle's record.
                if (cmd_stop || ((limit_q != '0) && (count_d == limit_q)))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done && (fcnt_d == '0))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM, statistics and registered controls
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            clr_run_q   <= 1'b0;
            drain_cnt_q <= '0;
            limit_q     <= '0;
            count_q     <= '0;
            lost_q      <= '0;
            ovf_q       <= 1'b0;
            rst_cnt_q   <= 1'b0;
            cnt_op_q    <= 1'b0;
            cap_op_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_run_q <= clr_run_d;

            if (state_q != ST_DRAIN)
                drain_cnt_q <= '0;
            else if (!drain_done)
                drain_cnt_q <= drain_cnt_q + DCW'(1);

            if ((state_q == ST_IDLE) && cmd_start) begin
                limit_q <= record_limit;
                count_q <= '0;
                lost_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                count_q <= count_d;
                if (drop) begin
                    ovf_q <= 1'b1;
                    if (lost_q != 16'hFFFF) lost_q <= lost_q + 16'd1;
                end
            end

            rst_cnt_q <= (state_d == ST_CLEAR);
            cnt_op_q  <= (state_d == ST_RUN);
            cap_op_q  <= (state_d == ST_RUN);
            done_q    <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage carries no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tag_data;
    end

    assign out_valid       = !fifo_empty;
    assign out_data        = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign reset_counter   = rst_cnt_q;
    assign counter_operate = cnt_op_q;
    assign capture_operate = cap_op_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign overflow        = ovf_q;
    assign lost_count      = lost_q;
    assign record_count    = count_q;

endmodule

// File: tb/tb_tagger_run_controller.sv
module tb_tagger_run_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_start, cmd_stop, cmd_clear;
    logic [31:0] record_limit;
    logic [46:0] tag_data;
    logic        tag_ready;
    logic        reset_counter, counter_operate, capture_operate;
    logic [46:0] out_data;
    logic        out_valid, out_accept, busy, done, overflow;
    logic [15:0] lost_count;
    logic [31:0] record_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tagger_run_controller dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear),
        .record_limit(record_limit), .tag_data(tag_data), .tag_ready(tag_ready),
        .reset_counter(reset_counter), .counter_operate(counter_operate),
        .capture_operate(capture_operate), .out_data(out_data),
        .out_valid(out_valid), .out_accept(out_accept), .busy(busy),
        .done(done), .overflow(overflow), .lost_count(lost_count),
        .record_count(record_count)
    );

    typedef struct {
        logic        start, stop, clr;
        logic [31:0] limit;
        logic        trdy;
        logic [46:0] tdata;
        logic        acc;
        logic        e_rc, e_co, e_cap, e_busy, e_done, e_vld;
        logic [46:0] e_data;
        logic [31:0] e_rec;
        logic [15:0] e_lost;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [21];

    function automatic logic [46:0] ch(input int n);
        return (47'(1) << 36) | 47'(n);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_start = 0; cmd_stop = 0; cmd_clear = 0; tag_ready = 0;
        tag_data = '0; record_limit = '0;
    endtask

    logic [46:0] W1, W2, Z;
    logic [46:0] exp_q [4];
    bit          seen;

    initial begin
        Z  = '0;
        W1 = 47'(1) << 46;
        W2 = (47'(1) << 46) | 47'd5;
        //            st st cl lim trdy tdata  acc | rc co ca bu dn vl data  rec lost ovf
        vecs[0]  = '{1, 0, 0, 3, 0, Z,      1,  1, 0, 0, 1, 0, 0, Z,      0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, Z,      1,  0, 1, 1, 1, 0, 0, Z,      0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, ch(1),  1,  0, 1, 1, 1, 0, 1, ch(1),  1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, ch(2),  1,  0, 1, 1, 1, 0, 1, ch(2),  2, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 1, ch(3),  1,  0, 0, 0, 1, 0, 1, ch(3),  3, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 1, ch(4),  1,  0, 0, 0, 1, 0, 0, Z,      3, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, ch(5),  1,  0, 0, 0, 1, 0, 0, Z,      3, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, Z,      1,  0, 0, 0, 1, 0, 0, Z,      3, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, Z,      1,  0, 0, 0, 0, 1, 0, Z,      3, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, Z,      1,  0, 0, 0, 0, 0, 0, Z,      3, 0, 0};
        vecs[10] = '{1, 1, 0, 0, 0, Z,      0,  1, 0, 0, 1, 0, 0, Z,      0, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 0, Z,      0,  0, 1, 1, 1, 0, 0, Z,      0, 0, 0};
        vecs[12] = '{0, 0, 1, 0, 1, W1,     0,  0, 1, 1, 1, 0, 1, W1,     0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 1, ch(7),  0,  0, 1, 1, 1, 0, 1, W1,     1, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 1, W2,     1,  0, 1, 1, 1, 0, 1, ch(7),  1, 0, 0};
        vecs[15] = '{0, 1, 0, 0, 1, ch(8),  1,  0, 0, 0, 1, 0, 1, W2,     2, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 1, ch(9),  1,  0, 0, 0, 1, 0, 1, ch(8),  3, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 0, Z,      1,  0, 0, 0, 1, 0, 1, ch(9),  3, 0, 0};
        vecs[18] = '{0, 0, 0, 0, 0, Z,      1,  0, 0, 0, 1, 0, 0, Z,      3, 0, 0};
        vecs[19] = '{0, 0, 0, 0, 0, Z,      1,  0, 0, 0, 0, 1, 0, Z,      3, 0, 0};
        vecs[20] = '{0, 0, 0, 0, 0, Z,      1,  0, 0, 0, 0, 0, 0, Z,      3, 0, 0};

        // Reset state
        reset_n = 0; out_accept = 0;
        idle_inputs();
        #12;
        check("rst.reset_counter", 64'(reset_counter), 0);
        check("rst.counter_operate", 64'(counter_operate), 0);
        check("rst.capture_operate", 64'(capture_operate), 0);
        check("rst.busy", 64'(busy), 0);
        check("rst.done", 64'(done), 0);
        check("rst.out_valid", 64'(out_valid), 0);
        check("rst.record_count", 64'(record_count), 0);
        check("rst.lost_count", 64'(lost_count), 0);
        check("rst.overflow", 64'(overflow), 0);
        @(negedge clk);
        reset_n = 1;
        tick();

        // Table: limit=3 run with auto-drain, then start+stop run with wrap records
        for (int i = 0; i < 21; i++) begin
            cmd_start = vecs[i].start; cmd_stop = vecs[i].stop; cmd_clear = vecs[i].clr;
            record_limit = vecs[i].limit; tag_ready = vecs[i].trdy;
            tag_data = vecs[i].tdata; out_accept = vecs[i].acc;
            tick();
            check($sformatf("v%0d.reset_counter", i), 64'(reset_counter), 64'(vecs[i].e_rc));
            check($sformatf("v%0d.counter_operate", i), 64'(counter_operate), 64'(vecs[i].e_co));
            check($sformatf("v%0d.capture_operate", i), 64'(capture_operate), 64'(vecs[i].e_cap));
            check($sformatf("v%0d.busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("v%0d.done", i), 64'(done), 64'(vecs[i].e_done));
            check($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
            if (vecs[i].e_vld)
                check($sformatf("v%0d.out_data", i), 64'(out_data), 64'(vecs[i].e_data));
            check($sformatf("v%0d.record_count", i), 64'(record_count), 64'(vecs[i].e_rec));
            check($sformatf("v%0d.lost_count", i), 64'(lost_count), 64'(vecs[i].e_lost));
            check($sformatf("v%0d.overflow", i), 64'(overflow), 64'(vecs[i].e_ovf));
        end
        idle_inputs();

        // Overflow: 6 records into a 4-deep FIFO with the consumer stalled
        out_accept = 0;
        cmd_start = 1; tick(); cmd_start = 0; tick();
        tag_ready = 1;
        for (int i = 1; i <= 6; i++) begin
            tag_data = ch(i);
            tick();
            check($sformatf("ovf.head_stable%0d", i), 64'(out_data), 64'(ch(1)));
        end
        check("ovf.lost_count", 64'(lost_count), 2);
        check("ovf.overflow", 64'(overflow), 1);
        check("ovf.record_count", 64'(record_count), 4);
        // push and pop together while full: nothing dropped
        tag_data = ch(9); out_accept = 1;
        tick();
        check("ovf.fullpp_lost", 64'(lost_count), 2);
        check("ovf.fullpp_count", 64'(record_count), 5);
        check("ovf.fullpp_head", 64'(out_data), 64'(ch(2)));
        tag_ready = 0; out_accept = 0; cmd_stop = 1;
        tick();
        cmd_stop = 0;
        check("ovf.stop_ctrl", 64'(capture_operate), 0);
        exp_q[0] = ch(2); exp_q[1] = ch(3); exp_q[2] = ch(4); exp_q[3] = ch(9);
        out_accept = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf.drain_valid%0d", i), 64'(out_valid), 1);
            check($sformatf("ovf.drain_data%0d", i), 64'(out_data), 64'(exp_q[i]));
            tick();
        end
        check("ovf.empty", 64'(out_valid), 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1;
            else tick();
        end
        check("ovf.done_seen", 64'(seen), 1);
        check("ovf.sticky_overflow", 64'(overflow), 1);

        // Idle clear: one reset_counter pulse, no done, statistics kept
        tick();
        cmd_clear = 1; tick(); cmd_clear = 0;
        check("clr.reset_counter", 64'(reset_counter), 1);
        check("clr.busy", 64'(busy), 1);
        check("clr.counter_operate", 64'(counter_operate), 0);
        tick();
        check("clr.reset_counter_off", 64'(reset_counter), 0);
        check("clr.busy_off", 64'(busy), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen = 1;
            tick();
        end
        check("clr.no_done", 64'(seen), 0);
        check("clr.record_count_kept", 64'(record_count), 5);
        check("clr.lost_count_kept", 64'(lost_count), 2);

        // Reset mid-run with two records buffered
        out_accept = 0;
        cmd_start = 1; tick(); cmd_start = 0; tick();
        tag_ready = 1; tag_data = ch(1); tick();
        tag_data = ch(2); tick();
        tag_ready = 0;
        check("mid.valid_before", 64'(out_valid), 1);
        check("mid.busy_before", 64'(busy), 1);
        #2 reset_n = 0;
        #1;
        check("mid.counter_operate", 64'(counter_operate), 0);
        check("mid.capture_operate", 64'(capture_operate), 0);
        check("mid.busy", 64'(busy), 0);
        check("mid.out_valid", 64'(out_valid), 0);
        check("mid.record_count", 64'(record_count), 0);
        @(negedge clk);
        reset_n = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) seen = 1;
        end
        check("mid.no_done", 64'(seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tagger_run_controller.md
Name: tagger_run_controller

Overview:
Run-sequencing controller for the multichannel event tagger. Takes start, stop and clear commands and drives the tagger's reset_counter, counter_operate and capture_operate controls. Buffers the tagger's record stream in a small first-word-fall-through FIFO for a back-pressured downstream consumer. Enforces an optional per-run record limit and accounts for records dropped on overflow.

Parameters:
N_CHANNELS, 4, tagger channel count; the channel field is tag_data[36+N_CHANNELS-1:36].
DATA_WIDTH, 47, record width; must equal 43+N_CHANNELS, so bit DATA_WIDTH-1 is the wraparound flag.
FIFO_DEPTH, 4, record buffer entries; power of two, at least 2.
LIMIT_WIDTH, 32, width of record_limit and record_count.
DRAIN_CYCLES, 4, cycles to keep accepting trailing records after capture stops.

Ports:
clk  in  1  single clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_start  in  1  one-cycle pulse: begin run
cmd_stop  in  1  one-cycle pulse: end run
cmd_clear  in  1  one-cycle pulse: zero the tagger timer while idle
record_limit  in  LIMIT_WIDTH  channel records per run, 0 = unlimited; sampled on accepted cmd_start
tag_data  in  DATA_WIDTH  record from tagger
tag_ready  in  1  tag_data valid this cycle
reset_counter  out  1  tagger timer clear
counter_operate  out  1  tagger timer enable
capture_operate  out  1  tagger capture enable
out_data  out  DATA_WIDTH  FIFO head record
out_valid  out  1  out_data valid
out_accept  in  1  consumer takes head when out_valid=1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at run completion
overflow  out  1  sticky: at least one record dropped this run
lost_count  out  16  dropped records this run, saturates at 0xFFFF
record_count  out  LIMIT_WIDTH  channel records accepted this run

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, FIFO empty.
  - All outputs 0; lost_count and record_count are 0.
- All control outputs are registered and decoded from state:
  - IDLE: all three controls 0.
  - CLEAR: reset_counter=1 only.
  - RUN: counter_operate=1 and capture_operate=1.
  - DRAIN: all three controls 0.
- State transitions:
  - IDLE + cmd_start goes to CLEAR. This latches record_limit and clears record_count, lost_count and overflow. cmd_start wins over simultaneous cmd_stop or cmd_clear.
  - IDLE + cmd_clear (without cmd_start) goes to CLEAR and returns to IDLE with no run, no done, and statistics untouched.
  - A run CLEAR lasts 1 cycle, then goes to RUN.
  - RUN + cmd_stop goes to DRAIN. So does RUN with record_count == limit (limit != 0); limit is checked against the updated count.
  - cmd_start and cmd_clear are ignored outside IDLE.
  - DRAIN counts DRAIN_CYCLES cycles. It then waits for the FIFO to empty, goes to IDLE, and pulses done=1 on the first IDLE cycle.
- Record acceptance:
  - In RUN and DRAIN, tag_ready=1 pushes tag_data unless the limit has been reached.
  - tag_ready in IDLE/CLEAR is ignored and not counted.
  - A channel record has a nonzero channel field; it increments record_count.
  - A wraparound-only record (channel field 0) is forwarded but not counted.
- Limit exactness:
  - Once record_count == limit, further records in RUN/DRAIN are discarded silently: no lost_count, no overflow.
  - After cmd_stop with limit not reached, trailing DRAIN records are accepted and counted.
- FIFO:
  - First-word-fall-through: out_valid = not empty, out_data = head.
  - Head is stable while out_valid=1 and out_accept=0.
  - Pop on out_valid and out_accept.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Push when full and no pop: record dropped, overflow set, lost_count incremented (saturating). A dropped channel record is not counted in record_count.
- Count widths: record_count does not wrap; its maximum equals the limit, or 2^LIMIT_WIDTH-1 when unlimited (saturates).
- Reset mid-run: immediate return to IDLE with controls deasserted. FIFO contents are lost and done is not pulsed.

Test Plan:
- Reset then cmd_start with limit=0 -> reset_counter high exactly 1 cycle, then counter_operate=capture_operate=1. cmd_stop -> controls 0 next cycle, done pulses once after DRAIN_CYCLES+FIFO empty.
- limit=3, channel records on 5 consecutive cycles, out_accept=1 -> exactly 3 records out, record_count=3, lost_count=0, overflow=0, auto-DRAIN.
- Interleaved wrap-only record (bit 46=1, channel field 0) and channel records -> all forwarded in order, record_count counts channel records only.
- out_accept=0, 6 records with FIFO_DEPTH=4 -> 4 buffered, lost_count=2, overflow=1, head stable; then out_accept=1 drains records in arrival order.
- cmd_start and cmd_stop same cycle in IDLE -> run starts. cmd_clear while RUN -> ignored. cmd_clear in IDLE -> single reset_counter pulse, no done.
- reset_n low mid-RUN with 2 records buffered -> outputs 0 immediately, out_valid=0, no done.
